// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage and the load extender:
// opcodes, func3 width codes, FSM states and the alignment rule.
package mem_access_unit_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    HOLD
  } mau_state_e;

  // Halfwords need addr[0]==0 and words need addr[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [6:0] opcode,
                                         input logic [2:0] func3,
                                         input logic [1:0] addr_lo);
    logic half;
    logic word;
    half = ((opcode == OPC_LOAD) && ((func3 == FUNC3_H) || (func3 == FUNC3_HU))) ||
           ((opcode == OPC_STORE) && (func3 == FUNC3_H));
    word = ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) && (func3 == FUNC3_W);
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_store_lane_gen.sv
// Store lane generator: turns func3 and the low address bits into byte
// write enables and places the store data on every lane it may land in.
module store_lane_gen
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  we,
  output logic [31:0] wdata
);

  // Unknown store widths still complete, they just write nothing.
  always_comb begin
    we    = 4'b0000;
    wdata = 32'h0;
    case (func3)
      FUNC3_B: begin
        we    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      FUNC3_H: begin
        we    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      FUNC3_W: begin
        we    = 4'b1111;
        wdata = data;
      end
      default: begin
        we    = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store outstanding, raw word handed on for extension.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses without touching memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_inst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  mau_state_e        state;
  mau_state_e        state_nxt;
  mau_state_e        accept_dest;
  logic [31:0]       inst_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept;
  logic              req_is_mem;
  logic              req_misaligned;
  logic              is_store_q;
  logic              timeout_hit;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;

  assign accept     = req_valid & req_ready;
  assign req_is_mem = (req_inst[6:0] == OPC_LOAD) || (req_inst[6:0] == OPC_STORE);
  assign is_store_q = (inst_q[6:0] == OPC_STORE);

`ifdef MISALIGN_TRAP_EN
  assign req_misaligned = is_misaligned(req_inst[6:0], req_inst[14:12], req_addr[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  // Non-memory ops and trapped accesses go straight to the output beat.
  assign accept_dest = (req_is_mem && !req_misaligned) ? ISSUE : HOLD;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A response arriving on the timeout cycle still wins over the abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = accept_dest;
      ISSUE:     if (mem_req_ready) state_nxt = is_store_q ? HOLD : WAIT_RESP;
      WAIT_RESP: if (mem_resp_valid || timeout_hit) state_nxt = HOLD;
      HOLD: begin
        if (accept)         state_nxt = accept_dest;
        else if (out_ready) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state)
      IDLE:  req_ready = 1'b1;
      ISSUE: mem_req_valid = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        req_ready = out_ready;
      end
      default: begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      inst_q  <= req_inst;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      word_q  <= 32'h0;
      err_q   <= req_misaligned;
    end else if (state == WAIT_RESP) begin
      if (mem_resp_valid)   word_q <= mem_resp_data;
      else if (timeout_hit) err_q  <= 1'b1;
    end
  end

  // Held at zero outside WAIT_RESP so every wait starts fresh; saturates at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wait_cnt <= '0;
    else if (state != WAIT_RESP)  wait_cnt <= '0;
    else if (wait_cnt != '1)      wait_cnt <= wait_cnt + 1'b1;
  end

  store_lane_gen u_lanes (
    .func3   (inst_q[14:12]),
    .addr_lo (addr_q[1:0]),
    .data    (wdata_q),
    .we      (lane_we),
    .wdata   (lane_wdata)
  );

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_we    = is_store_q ? lane_we : 4'b0000;
  assign mem_wdata = is_store_q ? lane_wdata : 32'h0;
  assign out_word  = word_q;
  assign out_inst  = inst_q;
  assign out_addr  = addr_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a transaction-level model
// (latency, lanes and result computed from access size); honours MISALIGN_TRAP_EN.
module tb_mem_access_unit;

  localparam int T = 4;
  localparam logic [6:0] OP_LD = 7'h03;
  localparam logic [6:0] OP_ST = 7'h23;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_inst;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_inst(req_inst), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
  );

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opc;
    r[14:12] = f3;
    return r;
  endfunction

  // Access size in bytes; 0 means a width code with no defined size.
  function automatic int ref_nbytes(input logic [31:0] inst);
    if (inst[6:0] == OP_LD) begin
      case (inst[14:12])
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end else if (inst[6:0] == OP_ST) begin
      case (inst[14:12])
        3'd0:    return 1;
        3'd1:    return 2;
        3'd2:    return 4;
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] inst, input logic [31:0] addr);
    int n;
    n = ref_nbytes(inst);
    return TRAP_EN && (n > 1) && ((int'(addr[1:0]) % n) != 0);
  endfunction

  function automatic logic [3:0] ref_we(input logic [31:0] inst, input logic [31:0] addr);
    int n;
    int start;
    n = ref_nbytes(inst);
    if (inst[6:0] != OP_ST || n == 0) return 4'h0;
    start = (int'(addr[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << start);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] inst, input logic [31:0] d);
    int n;
    n = ref_nbytes(inst);
    if (inst[6:0] != OP_ST) return 32'h0;
    if (n == 1) return {24'h0, d[7:0]} * 32'h01010101;
    if (n == 2) return {16'h0, d[15:0]} * 32'h00010001;
    if (n == 4) return d;
    return 32'h0;
  endfunction

  // One transaction: accept (draining any held beat in the same cycle), run the
  // memory side to an open-loop schedule, then check the result beat and hold it.
  task automatic run_txn(input string name, input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] wd, input int s, input int d,
                         input logic [31:0] rdata, input int hold, input bit noise);
    bit          is_ld;
    bit          is_st;
    bit          issue;
    int          lat;
    logic [31:0] exp_word;
    logic        exp_err;
    is_ld = (inst[6:0] == OP_LD);
    is_st = (inst[6:0] == OP_ST);
    issue = (is_ld || is_st) && !ref_misaligned(inst, addr);
    if (!issue)     lat = 1;
    else if (is_st) lat = 2 + s;
    else            lat = 3 + s + ((d < T) ? d : T);
    exp_word = (issue && is_ld && d <= T) ? rdata : 32'h0;
    exp_err  = ref_misaligned(inst, addr) || (issue && is_ld && d > T);

    req_valid = 1'b1; req_inst = inst; req_addr = addr; req_wdata = wd; out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s accept: req_ready=%b want 1", name, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; out_ready = 1'b0; req_inst = $urandom; req_addr = $urandom;

    for (int c = 1; c <= lat; c++) begin
      mem_req_ready  = issue && (c == 1 + s);
      mem_resp_valid = noise && (c == 1);
      mem_resp_data  = $urandom;
      if (issue && is_ld && d <= T && c == 2 + s + d) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
      end
      #1;
      checks++;
      if (mem_req_valid !== (issue && c <= 1 + s)) begin
        failures++;
        $display("[TB] FAIL %s mem_req_valid c=%0d: got %b want %b", name, c, mem_req_valid, issue && c <= 1 + s);
      end
      checks++;
      if (out_valid !== (c == lat)) begin
        failures++;
        $display("[TB] FAIL %s out_valid c=%0d: got %b want %b", name, c, out_valid, c == lat);
      end
      if (c < lat) begin
        checks++;
        if (req_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s busy req_ready c=%0d: got %b want 0", name, c, req_ready);
        end
      end
      if (issue && c == 1) begin
        checks++;
        if (mem_addr !== {addr[31:2], 2'b00}) begin
          failures++;
          $display("[TB] FAIL %s mem_addr: got %h want %h", name, mem_addr, {addr[31:2], 2'b00});
        end
        checks++;
        if (mem_we !== ref_we(inst, addr)) begin
          failures++;
          $display("[TB] FAIL %s mem_we: got %b want %b", name, mem_we, ref_we(inst, addr));
        end
        checks++;
        if (mem_wdata !== ref_wdata(inst, wd)) begin
          failures++;
          $display("[TB] FAIL %s mem_wdata: got %h want %h", name, mem_wdata, ref_wdata(inst, wd));
        end
      end
      if (c < lat) @(negedge clk);
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;

    checks++;
    if (out_word !== exp_word) begin
      failures++;
      $display("[TB] FAIL %s out_word: got %h want %h", name, out_word, exp_word);
    end
    checks++;
    if (out_err !== exp_err) begin
      failures++;
      $display("[TB] FAIL %s out_err: got %b want %b", name, out_err, exp_err);
    end
    checks++;
    if (out_inst !== inst || out_addr !== addr) begin
      failures++;
      $display("[TB] FAIL %s out_inst/out_addr: got %h/%h want %h/%h", name, out_inst, out_addr, inst, addr);
    end

    // A stray response while holding the beat must not disturb it.
    for (int h = 0; h < hold; h++) begin
      mem_resp_valid = (h == 0);
      mem_resp_data  = $urandom;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_word !== exp_word || out_err !== exp_err) begin
        failures++;
        $display("[TB] FAIL %s hold h=%0d: valid/word/err %b/%h/%b want 1/%h/%b",
                 name, h, out_valid, out_word, out_err, exp_word, exp_err);
      end
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain: out_valid=%b req_ready=%b want 0/1", out_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_inst = mk_inst(OP_LD, 3'd2); req_addr = 32'h40;
    req_wdata = 32'h0; mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h5555AAAA;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset handshakes: req_ready/mem_req_valid/out_valid %b/%b/%b want 1/0/0",
               req_ready, mem_req_valid, out_valid);
    end
    checks++;
    if (out_word !== 32'h0 || out_err !== 1'b0 || out_inst !== 32'h0 || out_addr !== 32'h0 ||
        mem_addr !== 32'h0 || mem_we !== 4'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset outputs: word=%h err=%b inst=%h addr=%h maddr=%h we=%b wd=%h want all 0",
               out_word, out_err, out_inst, out_addr, mem_addr, mem_we, mem_wdata);
    end
    req_valid = 1'b0; mem_req_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    #1;
    mem_resp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset stale resp: out_valid/mem_req_valid/req_ready %b/%b/%b want 0/0/1",
               out_valid, mem_req_valid, req_ready);
    end
  endtask

  task automatic test_store_byte();
    run_txn("sb", mk_inst(OP_ST, 3'd0), 32'h1003, 32'h000000AB, 0, 0, 32'h0, 1, 1'b0);
    checks++;
    if (mem_we !== 4'b1000 || mem_wdata !== 32'hABABABAB) begin
      failures++;
      $display("[TB] FAIL sb lanes: we=%b wdata=%h want 1000/abababab", mem_we, mem_wdata);
    end
    drain();
  endtask

  task automatic test_load_word();
    run_txn("lw_hold", mk_inst(OP_LD, 3'd2), 32'h2000, 32'h0, 0, 3, 32'hDEADBEEF, 5, 1'b1);
    drain();
  endtask

  task automatic test_stores();
    run_txn("sw_stall", mk_inst(OP_ST, 3'd2), 32'h3000, 32'hCAFEF00D, 2, 0, 32'h0, 0, 1'b0);
    run_txn("sh_hi", mk_inst(OP_ST, 3'd1), 32'h3006, 32'h1234BEEF, 1, 0, 32'h0, 0, 1'b0);
    run_txn("st_f3_3", mk_inst(OP_ST, 3'd3), 32'h3008, 32'h11223344, 0, 0, 32'h0, 1, 1'b1);
    run_txn("alu", mk_inst(7'h33, 3'd0), 32'h12345678, 32'h9, 0, 0, 32'h0, 1, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_lh", mk_inst(OP_LD, 3'd1), 32'h2402, 32'h0, 0, 0, 32'h0000F00D, 0, 1'b0);
    run_txn("b2b_lbu", mk_inst(OP_LD, 3'd4), 32'h2405, 32'h0, 0, 1, 32'h00AB0000, 0, 1'b0);
    drain();
  endtask

  task automatic test_timeout();
    run_txn("timeout", mk_inst(OP_LD, 3'd2), 32'h4000, 32'h0, 0, 9, 32'h77777777, 2, 1'b0);
    run_txn("resp_at_limit", mk_inst(OP_LD, 3'd0), 32'h4001, 32'h0, 1, T, 32'h0BADCAFE, 1, 1'b0);
    drain();
  endtask

  task automatic test_misalign();
    run_txn("lw_mis", mk_inst(OP_LD, 3'd2), 32'h2002, 32'h0, 0, 1, 32'h12345678, 1, 1'b0);
    run_txn("sh_mis", mk_inst(OP_ST, 3'd1), 32'h2011, 32'hA5A5C3C3, 0, 0, 32'h0, 1, 1'b0);
    drain();
  endtask

  task automatic test_random();
    logic [6:0] opc;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    opc = OP_LD;
        2, 3:    opc = OP_ST;
        default: opc = 7'h13;
      endcase
      run_txn("random", mk_inst(opc, 3'($urandom_range(0, 7))), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 6), $urandom,
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_inst = mk_inst(OP_LD, 3'd2); req_addr = 32'h300; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid reset issue: mem_req_valid=%b want 1", mem_req_valid);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1 || out_inst !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mid reset abandon: mem_req_valid/out_valid/req_ready/out_inst %b/%b/%b/%h want 0/0/1/0",
               mem_req_valid, out_valid, req_ready, out_inst);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hFEEDFACE;
    @(negedge clk);
    #1;
    mem_resp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid reset no beat: out_valid/out_word/mem_req_valid %b/%h/%b want 0/0/0",
               out_valid, out_word, mem_req_valid);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_byte();
    test_load_word();
    test_stores();
    test_back_to_back();
    test_timeout();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage between execute and the load extender / writeback.
- Accepts one load/store per handshake from execute and issues a word-aligned request to data memory.
- Generates store byte-enables and lane-replicated store data.
- Captures the raw returned word, with its inst and addr, and presents it downstream for sign/zero extension; one transaction outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT_RESP before abort with error; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute has a transaction
- req_ready  out  1  unit can accept
- req_inst  in  32  full instruction (opcode [6:0], func3 [14:12])
- req_addr  in  32  effective byte address
- req_wdata  in  32  rs2 store data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_we  out  4  byte write enables (0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_resp_valid  in  1  read data valid (loads only)
- mem_resp_data  in  32  raw read word
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_word  out  32  raw memory word (0 for stores and non-memory ops)
- out_inst  out  32  captured instruction
- out_addr  out  32  captured byte address
- out_err  out  1  misaligned or timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs and captured registers 0 except req_ready=1.
- req_ready = (state==IDLE) | (state==HOLD & out_ready); a same-cycle drain+accept is legal.
- Handshakes: transfer on valid&ready. Source holds valid and payload stable until accepted.
- States:
  - IDLE: on accept, register inst/addr/wdata; load (opcode 7'h03) or store (7'h23) -> ISSUE; other opcode -> HOLD with out_word=0, out_err=0.
  - ISSUE: mem_req_valid=1. On mem_req_ready: store -> HOLD (out_word=0); load -> WAIT_RESP.
  - WAIT_RESP: on mem_resp_valid, capture mem_resp_data -> HOLD. If the counter reaches TIMEOUT_CYCLES first -> HOLD with out_err=1, out_word=0.
  - HOLD: out_valid=1. On out_ready -> IDLE, or -> IDLE-accept path if req_valid is in the same cycle.
- Minimum latency:
  - Load: accept -> out_valid in 3 cycles when memory responds 1 cycle after request acceptance.
  - Store: 2 cycles.
  - Non-memory op: 1 cycle.
- Store lanes, a=addr[1:0]:
  - SB (func3 000): we=4'b0001<<a, wdata={4{d[7:0]}}.
  - SH (001): we = addr[1] ? 4'b1100 : 4'b0011, wdata={2{d[15:0]}}.
  - SW (010): we=4'b1111, wdata=d.
  - Other func3: we=0 (no write, still completes).
- Load: mem_we=0, mem_wdata=0.
- mem_resp_valid outside WAIT_RESP is ignored, including stale responses after reset.
- Wait counter clears on entry to WAIT_RESP and saturates.
- Reset mid-transaction: abandon immediately; no out beat produced.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - A misaligned access skips ISSUE: IDLE -> HOLD directly, out_err=1, out_word=0, no memory request.
- Undefined: no check; low address bits only select lanes as above. out_err is set only by timeout.

Decomposition:
- Shared package: OPC_LOAD=7'h03, OPC_STORE=7'h23, FUNC3_B/H/W/BU/HU codes, state enum {IDLE, ISSUE, WAIT_RESP, HOLD}.
- The same package is used by the load extender.
- One sub-module: store_lane_gen (combinational: func3, addr[1:0], data -> we, wdata).

Test Plan:
- Reset with req_valid=1 -> req_ready=1, mem_req_valid=0, out_valid=0. No accept until rst_n=1.
- SB addr=0x1003, rs2=0x000000AB, mem_req_ready=1 -> mem_addr=0x1000, mem_we=4'b1000, mem_wdata=0xABABABAB; out_valid 2 cycles after accept, out_word=0.
- LW addr=0x2000, resp 0xDEADBEEF after 3 wait cycles -> out_word=0xDEADBEEF, out_inst/out_addr match; stays held while out_ready=0 for 5 cycles.
- Back-to-back LH then LBU with out_ready=1 -> second req accepted in the same cycle as the first drain; results in order.
- TIMEOUT_CYCLES=4, no response -> out_err=1 exactly 5 cycles after entering WAIT_RESP; a late mem_resp_valid is ignored.
- MISALIGN_TRAP_EN with LW addr=0x2002 -> no mem_req_valid, out_valid next cycle, out_err=1. Without the macro -> normal access to 0x2000.
